uart_mmio_fifo: RTL and testbench

Memory-mapped front end for the on-chip UART, between the bus's UART slave port and the bit-level UART serializer/deserializer. Gives the core a 3-register interface (DATA, STATUS, CTRL) backed by independent TX and RX byte FIFOs, so software can queue several bytes without polling every character. Adds sticky overflow/overrun flags and FIFO flush controls.

---
 rtl/uart_mmio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_mmio_fifo.sv | 118 +++++++++++
 tb/tb_uart_mmio_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Register offsets and STATUS/CTRL bit positions for the UART MMIO front end.
package uart_mmio_pkg;

  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_CTRL   = 4'h8;

  localparam int unsigned ST_RX_NONEMPTY  = 0;
  localparam int unsigned ST_TX_NOT_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_RX_OVR       = 3;
  localparam int unsigned ST_TX_OVF       = 4;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;
  localparam int unsigned STATUS_W        = 24;

  localparam int unsigned CTRL_FLUSH_RX  = 0;
  localparam int unsigned CTRL_FLUSH_TX  = 1;
  localparam int unsigned CTRL_CLR_FLAGS = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; flush overrides push and pop, push on full succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO DATA/STATUS/CTRL front end for the UART with TX and RX byte FIFOs and sticky error flags.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_uart_addr,
  input  logic            i_uart_write,
  input  logic            i_uart_read,
  input  logic [3:0]      i_uart_size,
  input  logic [XLEN-1:0] i_uart_din,
  output logic [XLEN-1:0] o_uart_dout,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]          addr;
  logic                wr_data, wr_ctrl, rd_data;
  logic                rx_flush, tx_flush, clr_flags;
  logic                rx_pop, tx_pop;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0]       rx_count, tx_count;
  logic [7:0]          rx_head;
  logic [STATUS_W-1:0] status_c;
  logic                rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
  logic [XLEN-1:0]     dout_q, dout_d;
  logic                unused_c;

  assign unused_c = ^{i_uart_size, i_uart_addr[XLEN-1:4], i_uart_din[XLEN-1:8]};

  assign addr      = i_uart_addr[3:0];
  assign wr_data   = i_uart_write & (addr == UART_DATA);
  assign wr_ctrl   = i_uart_write & (addr == UART_CTRL);
  assign rd_data   = i_uart_read  & (addr == UART_DATA);
  assign rx_flush  = wr_ctrl & i_uart_din[CTRL_FLUSH_RX];
  assign tx_flush  = wr_ctrl & i_uart_din[CTRL_FLUSH_TX];
  assign clr_flags = wr_ctrl & i_uart_din[CTRL_CLR_FLAGS];
  assign rx_pop    = rd_data & ~rx_empty;
  assign o_tx_valid = ~tx_empty;
  assign tx_pop    = o_tx_valid & i_tx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (i_rx_valid),
    .data_i  (i_rx_data),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (wr_data),
    .data_i  (i_uart_din[7:0]),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (o_tx_data)
  );

  always_comb begin
    status_c = '0;
    status_c[ST_RX_NONEMPTY] = ~rx_empty;
    status_c[ST_TX_NOT_FULL] = ~tx_full;
    status_c[ST_TX_EMPTY]    = tx_empty;
    status_c[ST_RX_OVR]      = rx_ovr_q;
    status_c[ST_TX_OVF]      = tx_ovf_q;
    status_c[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
    status_c[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
  end

  // A drop only counts when no pop frees a slot and no flush discards the byte; a new drop beats a clear.
  always_comb begin
    rx_ovr_d = (rx_ovr_q & ~clr_flags) | (i_rx_valid & rx_full & ~rx_pop & ~rx_flush);
    tx_ovf_d = (tx_ovf_q & ~clr_flags) | (wr_data & tx_full & ~tx_pop & ~tx_flush);
  end

  always_comb begin
    dout_d = dout_q;
    if (i_uart_read) begin
      case (addr)
        UART_DATA:   dout_d = XLEN'(rx_head);
        UART_STATUS: dout_d = XLEN'(status_c);
        default:     dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dout_q   <= '0;
      rx_ovr_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rx_ovr_q <= rx_ovr_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  assign o_uart_dout = dout_q;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register access, FIFO ordering, overflow flags, flushes and reset.
module tb_uart_mmio_fifo;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_uart_addr;
  logic        i_uart_write;
  logic        i_uart_read;
  logic [3:0]  i_uart_size;
  logic [31:0] i_uart_din;
  logic [31:0] o_uart_dout;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  uart_mmio_fifo #(.XLEN(32), .FIFO_DEPTH(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_uart_addr  (i_uart_addr),
    .i_uart_write (i_uart_write),
    .i_uart_read  (i_uart_read),
    .i_uart_size  (i_uart_size),
    .i_uart_din   (i_uart_din),
    .o_uart_dout  (o_uart_dout),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    i_uart_addr  = a;
    i_uart_din   = d;
    i_uart_write = 1'b1;
    tick();
    i_uart_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    i_uart_addr = a;
    i_uart_read = 1'b1;
    tick();
    i_uart_read = 1'b0;
    d = o_uart_dout;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_uart_addr = '0; i_uart_write = 1'b0; i_uart_read = 1'b0;
    i_uart_size = 4'hF; i_uart_din = '0; i_tx_ready = 1'b0;
    i_rx_data = '0; i_rx_valid = 1'b0;
    tick(); tick();
    check_eq("rst_dout", o_uart_dout, 32'h0);
    check_eq("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    check_eq("rst_tx_data", 32'(o_tx_data), 32'h0);
    i_rst = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("rst_status", rd, 32'h0000_0006);

    // TX ordering with serializer stalled, then draining
    bus_write(A_DATA, 32'h41);
    check_eq("tx_valid_after_write", 32'(o_tx_valid), 32'h1);
    check_eq("tx_head_after_write", 32'(o_tx_data), 32'h41);
    bus_write(A_DATA, 32'h42);
    bus_write(A_DATA, 32'h43);
    bus_read(A_STATUS, rd);
    check_eq("tx_count3_status", rd, 32'h0003_0002);
    i_tx_ready = 1'b1;
    check_eq("tx_drain0", 32'(o_tx_data), 32'h41);
    tick();
    check_eq("tx_drain1", 32'(o_tx_data), 32'h42);
    tick();
    check_eq("tx_drain2", 32'(o_tx_data), 32'h43);
    tick();
    check_eq("tx_drained_valid", 32'(o_tx_valid), 32'h0);
    i_tx_ready = 1'b0;

    // RX overrun, clear racing a new overrun, drain and final clear
    for (int i = 0; i < 17; i++) rx_byte(8'(i));
    bus_read(A_STATUS, rd);
    check_eq("rx_ovr_status", rd, 32'h0000_100F);
    i_rx_data = 8'h77; i_rx_valid = 1'b1;
    bus_write(A_CTRL, 32'h4);
    i_rx_valid = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("rx_clear_vs_ovr", rd, 32'h0000_100F);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, rd);
      check_eq($sformatf("rx_rd%0d", i), rd, 32'(i));
    end
    bus_read(A_DATA, rd);
    check_eq("rx_rd_empty", rd, 32'h0);
    bus_read(A_STATUS, rd);
    check_eq("rx_empty_ovr_status", rd, 32'h0000_000E);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, rd);
    check_eq("rx_ovr_cleared", rd, 32'h0000_0006);

    // RX push and pop on a full FIFO in one cycle
    for (int i = 0; i < 16; i++) rx_byte(8'(8'hA0 + i));
    i_rx_data = 8'h55; i_rx_valid = 1'b1;
    bus_read(A_DATA, rd);
    i_rx_valid = 1'b0;
    check_eq("rx_full_pushpop_rd", rd, 32'hA0);
    bus_read(A_STATUS, rd);
    check_eq("rx_full_pushpop_status", rd, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, rd);
      check_eq($sformatf("rx_pp_rd%0d", i), rd, (i < 15) ? 32'(8'hA1 + i) : 32'h55);
    end

    // TX overflow, push+pop on full, clear flag, drain order
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'(8'h30 + i));
    bus_read(A_STATUS, rd);
    check_eq("tx_full_status", rd, 32'h0010_0000);
    i_tx_ready = 1'b1;
    bus_write(A_DATA, 32'h99);
    i_tx_ready = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("tx_full_pushpop_status", rd, 32'h0010_0000);
    bus_write(A_DATA, 32'hEE);
    bus_read(A_STATUS, rd);
    check_eq("tx_ovf_status", rd, 32'h0010_0010);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, rd);
    check_eq("tx_ovf_cleared", rd, 32'h0010_0000);
    i_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("tx_full_drain%0d", i), 32'(o_tx_data), (i < 15) ? 32'(8'h31 + i) : 32'h99);
      tick();
    end
    check_eq("tx_full_drained_valid", 32'(o_tx_valid), 32'h0);
    i_tx_ready = 1'b0;

    // TX flush racing a serializer pop
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'(8'h10 + i));
    bus_read(A_STATUS, rd);
    check_eq("tx5_status", rd, 32'h0005_0002);
    i_tx_ready = 1'b1;
    bus_write(A_CTRL, 32'h2);
    check_eq("tx_flush_valid", 32'(o_tx_valid), 32'h0);
    i_tx_ready = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("tx_flush_status", rd, 32'h0000_0006);

    // RX flush wins over a same-cycle push
    rx_byte(8'h11);
    rx_byte(8'h22);
    i_rx_data = 8'h33; i_rx_valid = 1'b1;
    bus_write(A_CTRL, 32'h1);
    i_rx_valid = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("rx_flush_status", rd, 32'h0000_0006);
    bus_read(A_DATA, rd);
    check_eq("rx_flush_rd", rd, 32'h0);

    // Unmapped offset reads zero; CTRL reads zero
    bus_read(32'hC, rd);
    check_eq("unmapped_rd", rd, 32'h0);

    // Asynchronous reset with both FIFOs occupied
    bus_write(A_DATA, 32'h5A);
    bus_write(A_DATA, 32'h5B);
    rx_byte(8'h01);
    bus_read(A_STATUS, rd);
    check_eq("pre_rst_status", rd, 32'h0002_0103);
    #3 i_rst = 1'b1;
    #1;
    check_eq("async_rst_tx_valid", 32'(o_tx_valid), 32'h0);
    check_eq("async_rst_tx_data", 32'(o_tx_data), 32'h0);
    check_eq("async_rst_dout", o_uart_dout, 32'h0);
    tick();
    i_rst = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("post_rst_status", rd, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
